// File: rtl/fc_frame_rx.sv
// fc_frame_rx: delineates Fibre Channel frames (SOF..EOF) from a 32-bit
// 8b/10b-decoded word stream and delivers them on an Avalon-ST source
// through a show-ahead FIFO. Corrupt, truncated, over-long or overflowed
// frames are closed with an abort marker so every delivered frame has
// exactly one sop and one eop.
module fc_frame_rx #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_WORDS  = 540
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_datak,
    input  logic        in_valid,
    input  logic        link_active,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic        out_error,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_err
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int WCW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {HUNT, FRAME, ABORT_PEND} state_t;

    // FIFO entry layout: {sop, eop, err, data}
    localparam logic [34:0] ABORT_ENTRY = {3'b011, 32'h0};

    // input register
    logic [31:0]    in_data_q, in_data_d;
    logic [3:0]     in_datak_q, in_datak_d;
    logic           in_valid_q, in_valid_d;

    // framing state
    state_t         state_q, state_d;
    logic [WCW-1:0] wc_q, wc_d;
    logic [15:0]    ok_q, ok_d;
    logic [15:0]    err_q, err_d;

    // FIFO storage; the output register is the head entry and counts
    // toward occupancy
    logic [34:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           out_valid_q, out_valid_d;
    logic [34:0]    out_entry_q, out_entry_d;

    logic           word_ok, is_sof, is_eof, is_data;
    logic [7:0]     b3, b2, b1, b0;
    logic [CW-1:0]  occ;
    logic           full, pop, load;
    logic           push;
    logic [34:0]    push_entry;
    logic           ok_inc, err_inc;

    // word classification on the registered input
    always_comb begin
        b3      = in_data_q[31:24];
        b2      = in_data_q[23:16];
        b1      = in_data_q[15:8];
        b0      = in_data_q[7:0];
        word_ok = in_valid_q & link_active;
        is_sof  = word_ok && in_datak_q == 4'b1000 && b3 == 8'hBC && b2 == 8'hB5
                  && b1 == b0 && (b1 == 8'h56 || b1 == 8'h36);
        is_eof  = word_ok && in_datak_q == 4'b1000 && b3 == 8'hBC
                  && (b2 == 8'h95 || b2 == 8'hB5)
                  && b1 == b0 && (b1 == 8'h75 || b1 == 8'hD5);
        is_data = word_ok && in_datak_q == 4'b0000;
    end

    // framing decisions; "full" is occupancy before any pop this cycle
    always_comb begin
        in_data_d  = in_data;
        in_datak_d = in_datak;
        in_valid_d = in_valid;
        occ        = cnt_q + CW'(out_valid_q);
        full       = (occ == CW'(FIFO_DEPTH));
        state_d    = state_q;
        wc_d       = wc_q;
        push       = 1'b0;
        push_entry = ABORT_ENTRY;
        ok_inc     = 1'b0;
        err_inc    = 1'b0;
        case (state_q)
            HUNT: begin
                if (is_sof) begin
                    if (full) begin
                        err_inc = 1'b1;
                    end else begin
                        push       = 1'b1;
                        push_entry = {3'b100, in_data_q};
                        wc_d       = WCW'(1);
                        state_d    = FRAME;
                    end
                end
            end
            FRAME: begin
                if (is_data && wc_q != WCW'(MAX_WORDS - 1)) begin
                    if (full) begin
                        state_d = ABORT_PEND;
                    end else begin
                        push       = 1'b1;
                        push_entry = {3'b000, in_data_q};
                        wc_d       = wc_q + WCW'(1);
                    end
                end else if (is_eof) begin
                    if (full) begin
                        state_d = ABORT_PEND;
                    end else begin
                        push       = 1'b1;
                        push_entry = {3'b010, in_data_q};
                        ok_inc     = 1'b1;
                        state_d    = HUNT;
                    end
                end else begin
                    // SOF, stray K, invalid word or length limit hit
                    if (full) begin
                        state_d = ABORT_PEND;
                    end else begin
                        push    = 1'b1;
                        err_inc = 1'b1;
                        state_d = HUNT;
                    end
                end
            end
            ABORT_PEND: begin
                if (!full) begin
                    push    = 1'b1;
                    err_inc = 1'b1;
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
        ok_d  = (ok_inc  && ok_q  != 16'hFFFF) ? ok_q  + 16'd1 : ok_q;
        err_d = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    end

    // FIFO pointers and show-ahead output register
    always_comb begin
        pop         = out_valid_q & out_ready;
        load        = (cnt_q != '0) && (!out_valid_q || out_ready);
        cnt_d       = cnt_q + CW'(push) - CW'(load);
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(load);
        out_valid_d = out_valid_q;
        out_entry_d = out_entry_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_entry_d = fifo_mem_q[rd_ptr_q];
        end else if (pop) begin
            out_valid_d = 1'b0;
            out_entry_d = '0;
        end
    end

    // FIFO storage array, written only on push (contents need no reset)
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
    end

    // all control state, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_data_q   <= '0;
            in_datak_q  <= '0;
            in_valid_q  <= 1'b0;
            state_q     <= HUNT;
            wc_q        <= '0;
            ok_q        <= '0;
            err_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_entry_q <= '0;
        end else begin
            in_data_q   <= in_data_d;
            in_datak_q  <= in_datak_d;
            in_valid_q  <= in_valid_d;
            state_q     <= state_d;
            wc_q        <= wc_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_entry_q <= out_entry_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_startofpacket = out_entry_q[34];
    assign out_endofpacket   = out_entry_q[33];
    assign out_error         = out_entry_q[32];
    assign out_data          = out_entry_q[31:0];
    assign frames_ok         = ok_q;
    assign frames_err        = err_q;

endmodule

// File: tb/tb_fc_frame_rx.sv
// tb_fc_frame_rx: directed and randomized checks of fc_frame_rx against a
// queue-based behavioural model of the framing rules.
module tb_fc_frame_rx;

    localparam int DEPTH = 4;
    localparam int MAXW  = 8;
    localparam logic [31:0] SOF = 32'hBCB55656;
    localparam logic [31:0] EOF = 32'hBC957575;
    localparam logic [3:0]  K   = 4'b1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_data;
    logic [3:0]  in_datak;
    logic        in_valid;
    logic        link_active;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic        out_error;
    logic [15:0] frames_ok;
    logic [15:0] frames_err;

    fc_frame_rx #(.FIFO_DEPTH(DEPTH), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_datak(in_datak), .in_valid(in_valid),
        .link_active(link_active),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_error(out_error), .frames_ok(frames_ok), .frames_err(frames_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        bit          sop;
        bit          eop;
        bit          err;
        int          t;
    } ent_t;

    // model state
    ent_t        q[$];
    int          cyc = 0;
    int          mode = 0;   // 0 hunting, 1 inside frame, 2 marker owed
    int          wc = 0;
    logic [31:0] m_d = '0;
    logic [3:0]  m_k = '0;
    logic        m_v = 1'b0;
    int          m_ok = 0;
    int          m_err = 0;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [34:0] dlog[$];
    logic [34:0] exp_q[$];
    bit          rnd_mode = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic int kind(logic [31:0] d, logic [3:0] k);
        if (k == 4'b0000) return 0;
        if (k == 4'b1000 && d[31:24] == 8'hBC && d[15:8] == d[7:0]) begin
            if (d[23:16] == 8'hB5 && (d[15:8] == 8'h56 || d[15:8] == 8'h36)) return 1;
            if ((d[23:16] == 8'h95 || d[23:16] == 8'hB5) &&
                (d[15:8] == 8'h75 || d[15:8] == 8'hD5)) return 2;
        end
        return 3;
    endfunction

    function automatic int sat(int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    function automatic ent_t mk(logic [31:0] d, bit s, bit e, bit r, int t);
        ent_t x;
        x.d = d; x.sop = s; x.eop = e; x.err = r; x.t = t;
        return x;
    endfunction

    // behavioural model: one step per rising edge
    initial begin
        int   kd;
        bit   full, vis;
        ent_t e;
        int   nmode;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                q.delete();
                mode = 0; wc = 0;
                m_v = 0; m_d = '0; m_k = '0;
                m_ok = 0; m_err = 0;
            end else begin
                cyc++;
                vis  = q.size() > 0 && q[0].t < cyc - 1;
                full = q.size() == DEPTH;
                if (vis && out_ready) void'(q.pop_front());
                kd = (m_v && link_active) ? kind(m_d, m_k) : 4;
                case (mode)
                    0: if (kd == 1) begin
                        if (full) m_err = sat(m_err);
                        else begin
                            q.push_back(mk(m_d, 1, 0, 0, cyc));
                            wc = 1; mode = 1;
                        end
                    end
                    1: begin
                        if (kd == 0 && wc + 1 < MAXW) begin e = mk(m_d, 0, 0, 0, cyc); nmode = 1; end
                        else if (kd == 2)            begin e = mk(m_d, 0, 1, 0, cyc); nmode = 0; end
                        else                         begin e = mk('0, 0, 1, 1, cyc); nmode = 0; end
                        if (full) mode = 2;
                        else begin
                            q.push_back(e);
                            if (nmode == 1) wc++;
                            else if (e.err) m_err = sat(m_err);
                            else m_ok = sat(m_ok);
                            mode = nmode;
                        end
                    end
                    default: if (!full) begin
                        q.push_back(mk('0, 0, 1, 1, cyc));
                        m_err = sat(m_err); mode = 0;
                    end
                endcase
                m_v = in_valid; m_d = in_data; m_k = in_datak;
            end
        end
    end

    // compare process: DUT outputs against the model every cycle
    initial begin
        bit vis;
        forever begin
            @(negedge clk);
            vis = q.size() > 0 && q[0].t < cyc;
            chk("out_valid", 64'(out_valid), 64'(vis));
            if (vis) begin
                chk("out_data", 64'(out_data), 64'(q[0].d));
                chk("out_sop", 64'(out_startofpacket), 64'(q[0].sop));
                chk("out_eop", 64'(out_endofpacket), 64'(q[0].eop));
                chk("out_error", 64'(out_error), 64'(q[0].err));
            end
            chk("frames_ok", 64'(frames_ok), 64'(m_ok));
            chk("frames_err", 64'(frames_err), 64'(m_err));
            if (out_valid === 1'b1 && out_ready === 1'b1)
                dlog.push_back({out_startofpacket, out_endofpacket, out_error, out_data});
        end
    end

    task automatic drv(logic [31:0] d, logic [3:0] k, logic v);
        in_data = d; in_datak = k; in_valid = v;
        if (rnd_mode) begin
            out_ready   = ($urandom_range(0, 3) != 0);
            link_active = ($urandom_range(0, 40) != 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drv('0, '0, 1'b0);
    endtask

    task automatic check_log(string nm);
        chk({nm, "_len"}, 64'(dlog.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < dlog.size(); i++)
            chk($sformatf("%s_w%0d", nm, i), 64'(dlog[i]), 64'(exp_q[i]));
        dlog.delete();
        exp_q.delete();
    endtask

    function automatic logic [34:0] E(bit s, bit e, bit r, logic [31:0] d);
        return {s, e, r, d};
    endfunction

    initial begin
        in_data = '0; in_datak = '0; in_valid = 1'b0;
        out_ready = 1'b0; link_active = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_ok", 64'(frames_ok), 64'd0);
        chk("rst_err", 64'(frames_err), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        // good frame and first-word latency
        out_ready = 1'b1;
        drv(SOF, K, 1);
        drv(32'h11111111, 4'h0, 1);
        chk("lat_edge1_valid", 64'(out_valid), 64'd0);
        drv(32'h22222222, 4'h0, 1);
        chk("lat_edge2_valid", 64'(out_valid), 64'd1);
        chk("lat_edge2_sop", 64'(out_startofpacket), 64'd1);
        drv(EOF, K, 1);
        idle(5);
        exp_q = '{E(1,0,0,SOF), E(0,0,0,32'h11111111), E(0,0,0,32'h22222222), E(0,1,0,EOF)};
        check_log("good");
        chk("good_ok", 64'(frames_ok), 64'd1);
        chk("good_err", 64'(frames_err), 64'd0);

        // truncated by an idle ordered set
        drv(SOF, K, 1);
        drv(32'hA5A5A5A5, 4'h0, 1);
        drv(32'hBC95B5B5, K, 1);
        idle(5);
        exp_q = '{E(1,0,0,SOF), E(0,0,0,32'hA5A5A5A5), E(0,1,1,32'h0)};
        check_log("trunc");
        chk("trunc_err", 64'(frames_err), 64'd1);

        // overflow with sink stalled
        out_ready = 1'b0;
        drv(SOF, K, 1);
        for (int i = 1; i <= 6; i++) drv(32'h30000000 + i, 4'h0, 1);
        drv(EOF, K, 1);
        idle(3);
        chk("ovf_held_valid", 64'(out_valid), 64'd1);
        chk("ovf_held_eop", 64'(out_endofpacket), 64'd0);
        chk("ovf_held_err", 64'(frames_err), 64'd1);
        out_ready = 1'b1;
        idle(8);
        exp_q = '{E(1,0,0,SOF), E(0,0,0,32'h30000001), E(0,0,0,32'h30000002),
                  E(0,0,0,32'h30000003), E(0,1,1,32'h0)};
        check_log("ovf");
        chk("ovf_err", 64'(frames_err), 64'd2);
        chk("ovf_ok", 64'(frames_ok), 64'd1);

        // length limit
        drv(SOF, K, 1);
        for (int i = 1; i <= 10; i++) drv(32'h40000000 + i, 4'h0, 1);
        idle(6);
        exp_q = '{E(1,0,0,SOF), E(0,0,0,32'h40000001), E(0,0,0,32'h40000002),
                  E(0,0,0,32'h40000003), E(0,0,0,32'h40000004), E(0,0,0,32'h40000005),
                  E(0,0,0,32'h40000006), E(0,1,1,32'h0)};
        check_log("len");
        chk("len_err", 64'(frames_err), 64'd3);

        // link drop mid-frame, then a clean frame
        drv(SOF, K, 1);
        drv(32'h50000001, 4'h0, 1);
        drv(32'h50000002, 4'h0, 1);
        link_active = 1'b0;
        drv('0, '0, 1'b0);
        link_active = 1'b1;
        idle(2);
        drv(32'hBCB53636, K, 1);
        drv(32'h50000003, 4'h0, 1);
        drv(32'hBCB5D5D5, K, 1);
        idle(6);
        exp_q = '{E(1,0,0,SOF), E(0,0,0,32'h50000001), E(0,1,1,32'h0),
                  E(1,0,0,32'hBCB53636), E(0,0,0,32'h50000003), E(0,1,0,32'hBCB5D5D5)};
        check_log("link");
        chk("link_ok", 64'(frames_ok), 64'd2);
        chk("link_err", 64'(frames_err), 64'd4);

        // randomized traffic, checked cycle by cycle against the model
        rnd_mode = 1;
        for (int f = 0; f < 300; f++) begin
            int nd, bad;
            logic [7:0] sb, eb2, eb1;
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                case ($urandom_range(0, 2))
                    0: drv($urandom, 4'h0, $urandom_range(0, 1));
                    1: drv(32'hBC95B5B5, K, 1);
                    default: drv($urandom, 4'($urandom), 1);
                endcase
            end
            sb  = ($urandom_range(0, 1) != 0) ? 8'h56 : 8'h36;
            eb2 = ($urandom_range(0, 1) != 0) ? 8'h95 : 8'hB5;
            eb1 = ($urandom_range(0, 1) != 0) ? 8'h75 : 8'hD5;
            nd  = $urandom_range(0, 9);
            bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, nd) : -1;
            drv({8'hBC, 8'hB5, sb, sb}, K, 1);
            for (int i = 0; i < nd; i++) begin
                if (i == bad) begin
                    case ($urandom_range(0, 2))
                        0: drv($urandom, 4'h0, 1'b0);
                        1: drv($urandom, 4'b0100, 1);
                        default: drv(SOF, K, 1);
                    endcase
                end else drv($urandom, 4'h0, 1);
            end
            drv({8'hBC, eb2, eb1, eb1}, K, 1);
        end
        rnd_mode = 0;
        out_ready = 1'b1; link_active = 1'b1;
        idle(12);
        chk("rnd_drained", 64'(out_valid), 64'd0);
        dlog.delete();

        // error counter saturation: dropped SOFs while the FIFO is full
        out_ready = 1'b0;
        drv(SOF, K, 1);
        drv(32'h60000001, 4'h0, 1);
        drv(32'h60000002, 4'h0, 1);
        drv(EOF, K, 1);
        for (int i = 0; i < 65540; i++) drv(SOF, K, 1);
        idle(2);
        chk("sat_err", 64'(frames_err), 64'hFFFF);
        out_ready = 1'b1;
        idle(8);
        exp_q = '{E(1,0,0,SOF), E(0,0,0,32'h60000001), E(0,0,0,32'h60000002), E(0,1,0,EOF)};
        check_log("sat_frame");
        chk("sat_err_hold", 64'(frames_err), 64'hFFFF);

        // reset mid-frame
        drv(SOF, K, 1);
        drv(32'h70000001, 4'h0, 1);
        drv(32'h70000002, 4'h0, 1);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_sop", 64'(out_startofpacket), 64'd0);
        chk("mid_rst_eop", 64'(out_endofpacket), 64'd0);
        chk("mid_rst_error", 64'(out_error), 64'd0);
        chk("mid_rst_ok", 64'(frames_ok), 64'd0);
        chk("mid_rst_err", 64'(frames_err), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        dlog.delete();
        idle(10);
        chk("post_rst_words", 64'(dlog.size()), 64'd0);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_err", 64'(frames_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_frame_rx.md
FC_FRAME_RX -- requirements
Module: fc_frame_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, output FIFO entries; power of two, minimum 4.
REQ-002 Parameter MAX_WORDS, default 540, maximum words per frame including SOF and EOF.
REQ-003 clk  in  1  rx word clock; sole clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_data  in  32  received word; byte 3 is first on the wire.
REQ-006 in_datak  in  4  per-byte K flag for in_data.
REQ-007 in_valid  in  1  in_data/in_datak valid this cycle.
REQ-008 link_active  in  1  link state machine reports Active state.
REQ-009 out_data  out  32  frame word.
REQ-010 out_valid  out  1  Avalon-ST valid.
REQ-011 out_ready  in  1  Avalon-ST ready; readyLatency 0.
REQ-012 out_startofpacket  out  1  first word of frame (SOF word).
REQ-013 out_endofpacket  out  1  last word of frame (EOF word or abort marker).
REQ-014 out_error  out  1  valid with out_endofpacket; frame is corrupt.
REQ-015 frames_ok  out  16  saturating count of frames ended by EOF.
REQ-016 frames_err  out  16  saturating count of aborted or dropped frames.

Function
REQ-017 Input is registered once; classification uses the registered word only when the registered in_valid=1 and link_active=1; otherwise the word is "invalid".
REQ-018 SOF = datak 4'b1000, byte3 8'hBC, byte2 8'hB5, byte1==byte0, byte1 in {8'h56, 8'h36}.
REQ-019 EOF = datak 4'b1000, byte3 8'hBC, byte2 in {8'h95, 8'hB5}, byte1==byte0, byte1 in {8'h75, 8'hD5}.
REQ-020 OTHER_K = any word with a nonzero datak that is not SOF or EOF; DATA = datak 4'b0000.
REQ-021 States HUNT, FRAME, ABORT_PEND; reset state HUNT.
REQ-022 HUNT: SOF with FIFO not full -> push {sop=1, data=word}, word count=1, go to FRAME.
REQ-023 HUNT: SOF with FIFO full -> drop the word, frames_err+1, stay in HUNT.
REQ-024 HUNT: all other words are discarded.
REQ-025 FRAME: DATA -> push the word and increment the word count.
REQ-026 FRAME: EOF -> push {eop=1, err=0}, frames_ok+1, go to HUNT.
REQ-027 FRAME: SOF, OTHER_K, or invalid word -> push abort marker, frames_err+1, go to HUNT.
REQ-028 Abort marker = {data=32'h0, sop=0, eop=1, err=1}.
REQ-029 FRAME: if a DATA word would make the word count reach MAX_WORDS -> push an abort marker instead of the word, frames_err+1, go to HUNT.
REQ-030 FRAME: any push with FIFO full -> drop the word and go to ABORT_PEND; the counter increments only when the marker is pushed.
REQ-031 ABORT_PEND: input is ignored; on the first cycle the FIFO is not full, push the abort marker, frames_err+1, go to HUNT.
REQ-032 A pop on the same cycle as a push is allowed; "full" means the occupancy before the pop.
REQ-033 Every frame delivered downstream has exactly one sop and one eop, with sop first; the SOF word itself is never an eop.
REQ-034 FIFO is show-ahead; out_* fields are valid whenever out_valid=1.
REQ-035 Pop on out_valid & out_ready; output fields hold stable while out_valid=1 and out_ready=0.
REQ-036 Latency: a word sampled at edge N reaches the output with out_valid=1 after edge N+2 when the FIFO is empty.
REQ-037 frames_ok and frames_err saturate at 16'hFFFF and never wrap.

Reset
REQ-038 On reset_n low, all of the following happen immediately:
  - state goes to HUNT;
  - the FIFO is emptied;
  - out_valid=0, out_startofpacket=0, out_endofpacket=0, out_error=0, out_data=0;
  - frames_ok=0, frames_err=0;
  - the input register is cleared.
REQ-039 Reset asserted mid-frame discards the partial frame with no abort marker; after reset release the block hunts for a new SOF.

Verification
REQ-040 Good frame: SOF BC_B5_56_56 K=1000, DATA 11111111, 22222222, EOF BC_95_75_75 K=1000, out_ready=1 -> 4 words out, sop on word 1, eop on word 4, error=0; frames_ok=1; first out_valid 2 cycles after SOF is sampled.
REQ-041 Truncated frame: SOF, DATA A5A5A5A5, then idle BC_95_B5_B5 -> out: SOF(sop), A5A5A5A5, 00000000 (eop=1, error=1); frames_err=1.
REQ-042 Overflow: FIFO_DEPTH=4, out_ready=0, SOF + 6 DATA + EOF -> FIFO holds 4 words; no eop until out_ready=1. Then: one pop frees a slot; the abort marker is pushed as entry 5 (eop=1, error=1); frames_err=1; EOF ignored; frames_ok=0.
REQ-043 Length limit: MAX_WORDS=8, SOF + 10 DATA -> 7 words out, then the abort marker; frames_err=1; later DATA discarded until the next SOF.
REQ-044 link_active deasserted mid-frame -> abort marker next push; a following SOF..EOF frame is delivered cleanly; frames_ok=1, frames_err=1.
REQ-045 Saturation plus reset: force 65536 aborted frames -> frames_err=16'hFFFF. Then: pulse reset_n low mid-frame -> all outputs 0 immediately; no marker emitted after release.
